adder_4bit: RTL and testbench
=============================

Name: adder_4bit

Overview:
- Registered ripple-carry adder producing a WIDTH-bit sum and a carry-out from two WIDTH-bit unsigned operands plus a carry-in.
- Single-stage pipelined arithmetic leaf in the datapath: one-cycle latency, with a valid qualifier on input and output.
- Default configuration is the 4-bit adder used by the arithmetic blocks.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1 to 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- carry_in  input  1  carry into bit 0
- in_valid  input  1  operands valid this cycle
- sum  output  WIDTH  registered sum bits [WIDTH-1:0]
- carry_out  output  1  registered carry out of MSB (unsigned overflow)
- overflow  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB
- out_valid  output  1  sum, carry_out and overflow hold a new result

Behaviour:
- Datapath:
  - Explicit chain of WIDTH full-adder cells built with a generate loop.
  - Each cell: s = x^y^c; co = (x&y)|(c&(x^y)).
  - Cell 0 takes carry_in; cell i takes the carry from cell i-1.
  - The combinational result is {carry_out, sum} = a + b + carry_in, computed at WIDTH+1 bits with no truncation of the carry.
- Reset: on a rising clk with rst_n=0, sum=0, carry_out=0, overflow=0, out_valid=0. Reset has priority over in_valid.
- Accept: on a rising clk with rst_n=1 and in_valid=1:
  - sum, carry_out and overflow load the combinational result of the current a, b and carry_in.
  - out_valid goes to 1.
  - Latency is exactly 1 cycle.
- Idle: on a rising clk with rst_n=1 and in_valid=0, out_valid goes to 0 and sum, carry_out and overflow hold their previous values.
- Throughput: one operation per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- No backpressure: the result must be consumed in the cycle out_valid=1.
- Wrap-around:
  - Results are modulo 2^WIDTH, with carry_out flagging a result of 2^WIDTH or more.
  - Example: a=F, b=1, carry_in=0 gives sum=0, carry_out=1.
  - Maximum case: a=F, b=F, carry_in=1 gives sum=F, carry_out=1.
- Reset mid-operation: a result accepted in the same cycle that rst_n=0 is discarded. Outputs go to their reset values and the next cycle shows out_valid=0.
- X handling: when in_valid=0, operand values are don't-care and must not propagate to the outputs.

Optional Feature:
- Macro: ADDER_4BIT_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with in_valid.
  - sub=1 computes a - b as a + ~b + 1. The B input to each cell is b^{WIDTH{sub}}, and the cell-0 carry is carry_in^sub.
  - carry_out in subtraction is the no-borrow flag: 1 when a >= b with carry_in=0.
  - overflow keeps its signed meaning.
  - sub=0 gives add behaviour identical to the undefined build.
- When undefined: no sub port and add-only behaviour. Area and timing must be identical to a build without the feature logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 and a=3, b=5 -> sum=0, carry_out=0, overflow=0, out_valid=0. Release -> first result appears one cycle after the first accepted edge.
- No carry: a=3, b=5, carry_in=0, in_valid=1 -> next cycle sum=8, carry_out=0, overflow=1 (3+5 overflows signed 4-bit), out_valid=1.
- Carry out: a=F, b=1, carry_in=0 -> sum=0, carry_out=1, overflow=0.
- Back-to-back then idle:
  - Cycle 0: a=9, b=6. Cycle 1: a=F, b=F, carry_in=1.
  - Results: sum=F, carry_out=0, then sum=F, carry_out=1, both with out_valid=1.
  - Cycle 2: in_valid=0 -> out_valid=0, sum stays F, carry_out stays 1.
- Reset mid-stream: in_valid=1 with a=7, b=7 in the same cycle rst_n=0 -> next cycle all outputs 0, out_valid=0. The operation is dropped.
- ADDER_4BIT_SUB_EN build:
  - sub=1, a=5, b=3, carry_in=0 -> sum=2, carry_out=1.
  - sub=1, a=3, b=5 -> sum=E, carry_out=0.
  - sub=1, a=8, b=1 -> sum=7, overflow=1.

Source files
------------

// File: rtl/adder_4bit.sv
// Registered ripple-carry adder, one-cycle latency, valid-qualified.
// Define ADDER_4BIT_SUB_EN to add a sub port (a - b via a + ~b + 1).
module adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef ADDER_4BIT_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;

`ifdef ADDER_4BIT_SUB_EN
  assign bx   = b ^ {WIDTH{sub}};
  assign c[0] = carry_in ^ sub;
`else
  assign bx   = b;
  assign c[0] = carry_in;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  // Result register: reset wins, accept loads, idle holds data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= s;
      carry_out <= c[WIDTH];
      overflow  <= c[WIDTH] ^ c[WIDTH-1];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_4bit.sv
// Scoreboard bench for adder_4bit against an arithmetic model.
// Covers reset, carry, back-to-back, idle hold and random traffic.
module tb_adder_4bit;
  localparam int W = 4;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);

  typedef struct packed {
    logic         valid;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         sub = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         out_valid;

  int checks = 0;
  int failures = 0;
  bit done = 0;
  exp_t q[$];
  exp_t held = '0;

  adder_4bit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .b(b),
    .carry_in(carry_in),
`ifdef ADDER_4BIT_SUB_EN
    .sub(sub),
`endif
    .in_valid(in_valid),
    .sum(sum),
    .carry_out(carry_out),
    .overflow(overflow),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic int sval(int v);
    return (v >= HALF) ? v - FULL : v;
  endfunction

  // Add/subtract from integer arithmetic on the operand values.
  function automatic exp_t model(int av, int bv, int ci, int sb);
    exp_t e;
    int bb, c0, u, sg;
    bb = sb ? (FULL - 1 - bv) : bv;
    c0 = ci ^ sb;
    u  = av + bb + c0;
    sg = sval(av) + sval(bb) + c0;
    e.valid = 1'b1;
    e.sum   = W'(u % FULL);
    e.co    = (u >= FULL);
    e.ovf   = (sg > HALF - 1) || (sg < -HALF);
    return e;
  endfunction

  task automatic cyc(input bit r, input bit v, input int av,
                     input int bv, input int ci, input int sb);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    a        = W'(av);
    b        = W'(bv);
    carry_in = ci[0];
    sub      = sb[0];
    @(posedge clk);
    if (!r) begin
      held = '0;
    end else if (v) begin
      held = model(av, bv, ci, sb);
    end else begin
      held.valid = 1'b0;
    end
    q.push_back(held);
  endtask

  // Monitor: one expected presentation per clock edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t got;
      e = q.pop_front();
      got = '{out_valid, sum, carry_out, overflow};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL out t=%0t got v=%b s=%h co=%b ov=%b want v=%b s=%h co=%b ov=%b",
                 $time, got.valid, got.sum, got.co, got.ovf,
                 e.valid, e.sum, e.co, e.ovf);
      end
    end
  end

  initial begin
    int sb;
    // reset held with traffic on the inputs
    cyc(0, 1, 3, 5, 0, 0);
    cyc(0, 1, 3, 5, 0, 0);
    // directed
    cyc(1, 1, 3, 5, 0, 0);
    cyc(1, 1, 15, 1, 0, 0);
    cyc(1, 1, 9, 6, 0, 0);
    cyc(1, 1, 15, 15, 1, 0);
    cyc(1, 0, 2, 2, 0, 0);
    cyc(1, 0, 7, 1, 1, 0);
    cyc(0, 1, 7, 7, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0);
`ifdef ADDER_4BIT_SUB_EN
    cyc(1, 1, 5, 3, 0, 1);
    cyc(1, 1, 3, 5, 0, 1);
    cyc(1, 1, 8, 1, 0, 1);
    cyc(1, 1, 5, 3, 0, 0);
`endif
    // random traffic
    for (int i = 0; i < 300; i++) begin
`ifdef ADDER_4BIT_SUB_EN
      sb = int'($urandom_range(1));
`else
      sb = 0;
`endif
      cyc(($urandom_range(19) != 0), ($urandom_range(3) != 0),
          int'($urandom_range(FULL - 1)),
          int'($urandom_range(FULL - 1)),
          int'($urandom_range(1)), sb);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

endmodule
